// File: rtl/i2c_write_arbiter_pkg.sv
// Shared definitions for the I2C write arbiter: FSM state encoding, parameter
// defaults, counter widths and the SCL prescale value used by the write engine.
package i2c_write_arbiter_pkg;

    localparam int unsigned N_REQ_DEF          = 4;
    localparam int unsigned GUARD_CYCLES_DEF   = 4;
    localparam int unsigned MAX_RETRY_DEF      = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 131072;   // ~1.05 ms at 125 MHz
    localparam int unsigned TO_W               = 18;       // saturating timeout counter width
    localparam int unsigned REC_CYCLES         = 2;        // engine reset pulse length
    localparam int unsigned SCL_PRESCALE       = 312;      // 125 MHz / (4 * 100 kHz)

    typedef enum logic [2:0] {
        ST_GUARD     = 3'd0,
        ST_ARB       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RECOVER   = 3'd4
    } arb_state_t;

    // Counter width for values 0..n-1, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_write_arbiter_rr.sv
// Round-robin selector: picks the first asserted request at or after ptr_i,
// wrapping around.
//  req_i   : request levels
//  ptr_i   : highest-priority index this round
//  grant_o : one-hot winner
//  idx_o   : winner index
//  valid_o : any request present
module i2c_write_arbiter_rr
    import i2c_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic [IW-1:0] j;

    // Scan from ptr_i upward; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = IW'((32'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one i2c_write_byte engine between N_REQ clients: round-robin grant,
// latched address/data, guard spacing between starts, NACK retry and hung-bus
// recovery via an engine reset pulse.
//  clk, reset              : clock, async active-high reset
//  req / req_dev_adr / req_reg_dat : per-client request level and payload bytes
//  req_done / req_err      : per-client completion / failure pulses
//  busy                    : transaction in flight
//  wr_dev_adr / wr_reg_dat / wr_start : engine command
//  wr_done / wr_error      : engine status
//  wr_reset                : engine reset (external reset OR recovery pulse)
module i2c_write_arbiter
    import i2c_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = N_REQ_DEF,
    parameter int unsigned GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_dev_adr,
    input  logic [8*N_REQ-1:0] req_reg_dat,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   req_err,
    output logic               busy,
    output logic [7:0]         wr_dev_adr,
    output logic [7:0]         wr_reg_dat,
    output logic               wr_start,
    input  logic               wr_done,
    input  logic               wr_error,
    output logic               wr_reset
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned RW = cnt_w(MAX_RETRY + 1);
    localparam int unsigned GW = cnt_w(GUARD_CYCLES);

    arb_state_t       state_q;
    logic [GW-1:0]    guard_cnt_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic [RW-1:0]    retry_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             rec_cnt_q;
    logic             err_seen_q;
    logic [N_REQ-1:0] grant_q;
    logic [7:0]       dev_q;
    logic [7:0]       dat_q;
    logic             busy_q;
    logic             start_q;
    logic [N_REQ-1:0] done_q;
    logic [N_REQ-1:0] err_q;
    logic             recover_q;

    logic [N_REQ-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [IW+2:0]    sel_lsb;
    logic             err_now;

    i2c_write_arbiter_rr #(.N_REQ(N_REQ)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_lsb = {arb_idx, 3'b000};
    assign ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    // An error flagged in the same cycle as done still counts as a failure.
    assign err_now = err_seen_q | wr_error;

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_GUARD;
            guard_cnt_q <= '0;
            ptr_q       <= '0;
            retry_q     <= '0;
            to_cnt_q    <= '0;
            rec_cnt_q   <= 1'b0;
            err_seen_q  <= 1'b0;
            grant_q     <= '0;
            dev_q       <= '0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= '0;
            err_q       <= '0;
            recover_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                ST_GUARD: begin
                    if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) begin
                        guard_cnt_q <= '0;
                        // A pending retry replays the latched command without re-arbitration.
                        state_q     <= (retry_q != '0) ? ST_START : ST_ARB;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        dev_q   <= req_dev_adr[sel_lsb +: 8];
                        dat_q   <= req_reg_dat[sel_lsb +: 8];
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    start_q    <= 1'b1;
                    to_cnt_q   <= '0;
                    err_seen_q <= 1'b0;
                    state_q    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (wr_error) begin
                        err_seen_q <= 1'b1;
                    end
                    if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                    if (wr_done) begin
                        state_q <= ST_GUARD;
                        if (!err_now) begin
                            done_q  <= grant_q;
                            busy_q  <= 1'b0;
                            retry_q <= '0;
                        end else if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            err_q   <= grant_q;
                            busy_q  <= 1'b0;
                            retry_q <= '0;
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= ST_RECOVER;
                        recover_q <= 1'b1;
                        rec_cnt_q <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (rec_cnt_q == 1'(REC_CYCLES - 1)) begin
                        recover_q <= 1'b0;
                        err_q     <= grant_q;
                        busy_q    <= 1'b0;
                        retry_q   <= '0;
                        state_q   <= ST_GUARD;
                    end else begin
                        rec_cnt_q <= rec_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_GUARD;
            endcase
        end
    end

    assign req_done   = done_q;
    assign req_err    = err_q;
    assign busy       = busy_q;
    assign wr_dev_adr = dev_q;
    assign wr_reg_dat = dat_q;
    assign wr_start   = start_q;
    assign wr_reset   = reset | recover_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Scoreboard bench for i2c_write_arbiter with a behavioural write-engine model
// (programmable NACK, coincident error/done, hang, spurious done).
module tb_i2c_write_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned G   = 4;
    localparam int unsigned MR  = 2;
    localparam int unsigned TO  = 200;
    localparam int unsigned LAT = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [8*N-1:0] req_dev_adr;
    logic [8*N-1:0] req_reg_dat;
    logic [N-1:0]  req_done;
    logic [N-1:0]  req_err;
    logic          busy;
    logic [7:0]    wr_dev_adr;
    logic [7:0]    wr_reg_dat;
    logic          wr_start;
    logic          wr_done = 1'b0;
    logic          wr_error = 1'b0;
    logic          wr_reset;

    i2c_write_arbiter #(
        .N_REQ(N), .GUARD_CYCLES(G), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_dev_adr(req_dev_adr), .req_reg_dat(req_reg_dat),
        .req_done(req_done), .req_err(req_err), .busy(busy),
        .wr_dev_adr(wr_dev_adr), .wr_reg_dat(wr_reg_dat), .wr_start(wr_start),
        .wr_done(wr_done), .wr_error(wr_error), .wr_reset(wr_reset)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] start_q[$];   // expected {dev, dat} per engine start
    logic [7:0]  out_q[$];     // expected {req_err, req_done} per pulse

    // Engine model controls
    bit       hang = 1'b0;
    bit       nack_en = 1'b0;
    logic [7:0] nack_dev = 8'h00;
    int       nack_from = 0;
    int       nack_cnt = 0;
    bit       coinc = 1'b0;
    int       spurious_req = 0;
    int       spurious_ack = 0;
    int       n_starts = 0;
    int       eng_cnt = 0;
    bit       eng_active = 1'b0;
    bit       eng_nack = 1'b0;

    int  reissue[N];
    bit  gap_check = 1'b0;
    bit  to_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write-engine model: done LAT cycles after start, error one cycle before done on NACK.
    always @(negedge clk) begin
        if (wr_reset) begin
            eng_active = 1'b0;
            wr_done    = 1'b0;
            wr_error   = 1'b0;
        end else begin
            wr_done  = 1'b0;
            wr_error = 1'b0;
            if (spurious_req != spurious_ack) begin
                wr_done      = 1'b1;
                spurious_ack = spurious_req;
            end
            if (eng_active) begin
                eng_cnt--;
                if (eng_cnt == 1 && eng_nack && !coinc) wr_error = 1'b1;
                if (eng_cnt == 0) begin
                    wr_done = 1'b1;
                    if (eng_nack && coinc) wr_error = 1'b1;
                    eng_active = 1'b0;
                end
            end
            if (wr_start && !hang) begin
                eng_active = 1'b1;
                eng_cnt    = LAT;
                eng_nack   = (nack_en && wr_dev_adr == nack_dev) || ((n_starts - nack_from) < nack_cnt);
                n_starts++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts the engine or pulses a client.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_start) begin
                if (start_q.size() == 0) begin
                    chk("unexpected_start", 32'(wr_start), 0);
                end else begin
                    logic [15:0] e;
                    e = start_q.pop_front();
                    chk("start_dev", 32'(wr_dev_adr), 32'(e[15:8]));
                    chk("start_dat", 32'(wr_reg_dat), 32'(e[7:0]));
                    chk("busy_at_start", 32'(busy), 1);
                end
            end
            if (|req_done || |req_err) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({req_err, req_done}), 0);
                end else begin
                    logic [7:0] e;
                    e = out_q.pop_front();
                    chk("pulse", 32'({req_err, req_done}), 32'(e));
                    chk("busy_at_pulse", 32'(busy), 0);
                end
            end
        end
    end

    task automatic set_client(input int i, input logic [7:0] dev, input logic [7:0] dat);
        req_dev_adr[8*i +: 8] = dev;
        req_reg_dat[8*i +: 8] = dat;
    endtask

    // Serve client handshakes until every expected event has been consumed.
    task automatic run_until_idle(input string tag, input int budget);
        int cyc = 0;
        int last_pulse = -1;
        int start_cyc = 0;
        int rst_hi = 0;
        bit fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (wr_start) begin
                if (gap_check && last_pulse >= 0) chk({tag, "_gap"}, 32'(cyc - last_pulse), G + 2);
                start_cyc = cyc;
            end
            if (wr_reset) begin
                if (rst_hi == 0 && to_check) chk({tag, "_timeout_lat"}, 32'(cyc - start_cyc), TO);
                rst_hi++;
            end
            for (int i = 0; i < N; i++) begin
                if (req_done[i] || req_err[i]) begin
                    last_pulse = cyc;
                    if (reissue[i] > 0) reissue[i]--;
                    else req[i] = 1'b0;
                end
            end
            if (req == '0 && out_q.size() == 0 && start_q.size() == 0) begin
                fin = 1'b1;
            end else if (cyc >= budget) begin
                chk({tag, "_budget_pending"}, 32'(out_q.size() + start_q.size()), 0);
                out_q.delete();
                start_q.delete();
                req = '0;
                fin = 1'b1;
            end
        end
        if (to_check) chk({tag, "_reset_cycles"}, 32'(rst_hi), 2);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (|req_done || |req_err || busy) n++;
        end
    endtask

    initial begin
        int s0;
        int k;
        int np;
        reset = 1'b1;
        req = '0;
        req_dev_adr = '0;
        req_reg_dat = '0;
        for (int i = 0; i < N; i++) reissue[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_start", 32'(wr_start), 0);
        chk("rst_req_done", 32'(req_done), 0);
        chk("rst_req_err", 32'(req_err), 0);
        chk("rst_wr_reset", 32'(wr_reset), 1);
        chk("rst_wr_dev", 32'(wr_dev_adr), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_reset", 32'(wr_reset), 0);
        repeat (8) @(negedge clk);

        // Single client 0, two-cycle request-to-start latency
        set_client(0, 8'hE8, 8'h04);
        start_q.push_back(16'hE804);
        out_q.push_back(8'h01);
        req[0] = 1'b1;
        @(negedge clk);
        chk("lat_cycle1", 32'(wr_start), 0);
        @(negedge clk);
        chk("lat_cycle2", 32'(wr_start), 1);
        run_until_idle("single", 100);

        // Reset mid-transaction: aborted silently, pointer returns to 0
        set_client(3, 8'h3C, 8'h99);
        start_q.push_back(16'h3C99);
        req[3] = 1'b1;
        k = 0;
        while (!wr_start && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_start_seen", 32'(wr_start), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_reset", 32'(wr_reset), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_pulses(25, np);
        chk("midrst_no_activity", 32'(np), 0);

        // All four at once: grants 0,1,2,3, guard spacing between starts
        for (int i = 0; i < N; i++) begin
            set_client(i, 8'(8'h10 + 2 * i), 8'(8'hA0 + i));
            start_q.push_back({8'(8'h10 + 2 * i), 8'(8'hA0 + i)});
            out_q.push_back(8'(1 << i));
        end
        gap_check = 1'b1;
        req = 4'hF;
        run_until_idle("all4", 300);
        gap_check = 1'b0;

        // Client 2 held, client 1 re-requests: 1,2,1,2
        set_client(1, 8'h21, 8'h11);
        set_client(2, 8'h22, 8'h12);
        start_q.push_back(16'h2111); out_q.push_back(8'h02);
        start_q.push_back(16'h2212); out_q.push_back(8'h04);
        start_q.push_back(16'h2111); out_q.push_back(8'h02);
        start_q.push_back(16'h2212); out_q.push_back(8'h04);
        reissue[1] = 1;
        reissue[2] = 1;
        req = 4'b0110;
        run_until_idle("rr", 300);

        // Address 0x40 always NACKed: 3 starts then req_err on client 2
        nack_en = 1'b1;
        nack_dev = 8'h40;
        set_client(2, 8'h40, 8'h55);
        repeat (3) start_q.push_back(16'h4055);
        out_q.push_back(8'h40);
        s0 = n_starts;
        req[2] = 1'b1;
        run_until_idle("nack_all", 300);
        chk("nack_all_starts", 32'(n_starts - s0), 3);
        nack_en = 1'b0;

        // First attempt NACKed only: 2 starts then req_done on client 3
        set_client(3, 8'h50, 8'h66);
        nack_from = n_starts;
        nack_cnt = 1;
        repeat (2) start_q.push_back(16'h5066);
        out_q.push_back(8'h08);
        s0 = n_starts;
        req[3] = 1'b1;
        run_until_idle("nack_first", 200);
        chk("nack_first_starts", 32'(n_starts - s0), 2);
        nack_cnt = 0;

        // Error coincident with done counts as error: retry then success on client 0
        coinc = 1'b1;
        set_client(0, 8'h61, 8'h77);
        nack_from = n_starts;
        nack_cnt = 1;
        repeat (2) start_q.push_back(16'h6177);
        out_q.push_back(8'h01);
        s0 = n_starts;
        req[0] = 1'b1;
        run_until_idle("coinc", 200);
        chk("coinc_starts", 32'(n_starts - s0), 2);
        nack_cnt = 0;
        coinc = 1'b0;

        // Hung bus on client 1: timeout, 2-cycle engine reset, req_err
        hang = 1'b1;
        to_check = 1'b1;
        set_client(1, 8'h70, 8'h01);
        start_q.push_back(16'h7001);
        out_q.push_back(8'h20);
        req[1] = 1'b1;
        run_until_idle("hang", 400);
        to_check = 1'b0;
        hang = 1'b0;

        // Next request served normally after recovery
        set_client(0, 8'h71, 8'h02);
        start_q.push_back(16'h7102);
        out_q.push_back(8'h01);
        req[0] = 1'b1;
        run_until_idle("after_hang", 100);

        // Spurious wr_done while idle is ignored
        repeat (3) @(negedge clk);
        spurious_req++;
        count_pulses(15, np);
        chk("spurious_ignored", 32'(np), 0);

        chk("end_start_q_empty", 32'(start_q.size()), 0);
        chk("end_out_q_empty", 32'(out_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
